// File: rtl/tx_frame_encoder.sv
// tx_frame_encoder: TX stage after tx_controller. It assigns a sequence ID to each data
// frame, forces illegal headers to a PAUSE control frame, and appends a CRC over
// header+payload. The CRC seed is the ID snapshot for data frames and all-ones for
// control frames.
// Optional build macro TX_SCRAMBLER_EN adds a third stage. That stage is a
// self-synchronous x^58+x^39+1 scrambler over everything below the header.
// Clocking: clk. Reset: rst, synchronous, active-high.
module tx_frame_encoder #(
    parameter int FRAME_WIDTH    = 256,
    parameter int PAYLOAD_WIDTH  = 240,
    parameter int FRAME_ID_WIDTH = 8,
    parameter logic [FRAME_WIDTH-PAYLOAD_WIDTH-5:0] CRC_POLY = 12'h80F
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [FRAME_WIDTH-1:0]    tx_frame,
    output logic [FRAME_WIDTH-1:0]    enc_frame,
    output logic                      enc_valid,
    output logic [FRAME_ID_WIDTH-1:0] tx_frame_id
);

    localparam int CRC_WIDTH  = FRAME_WIDTH - PAYLOAD_WIDTH - 4;
    localparam int BODY_WIDTH = FRAME_WIDTH - CRC_WIDTH;
    localparam int SCR_WIDTH  = FRAME_WIDTH - 2;
    // PAUSE-form control frame body that replaces any frame with an illegal header
    localparam logic [BODY_WIDTH-1:0] PAUSE_BODY = {2'b10, 16'h0010, {(BODY_WIDTH-18){1'b0}}};

    if ((CRC_WIDTH < FRAME_ID_WIDTH) || (CRC_WIDTH < 1)) begin : g_bad_params
        $error("tx_frame_encoder: CRC_WIDTH must be >= 1 and >= FRAME_ID_WIDTH");
    end

    // MSB-first, non-reflected CRC with no final XOR, starting from the given seed
    function automatic logic [CRC_WIDTH-1:0] crc_calc(input logic [BODY_WIDTH-1:0] body,
                                                      input logic [CRC_WIDTH-1:0]  seed);
        logic [CRC_WIDTH-1:0] crc;
        logic                 fb;
        crc = seed;
        for (int i = BODY_WIDTH - 1; i >= 0; i--) begin
            fb  = crc[CRC_WIDTH-1] ^ body[i];
            crc = crc << 1;
            if (fb) begin
                crc = crc ^ CRC_POLY;
            end else begin
                crc = crc;
            end
        end
        return crc;
    endfunction

    logic [BODY_WIDTH-1:0]     s1_body_s;
    logic                      s1_is_data_s;
    logic [BODY_WIDTH-1:0]     s1_body_r;
    logic                      s1_is_data_r;
    logic [FRAME_ID_WIDTH-1:0] s1_id_r;
    logic                      s1_valid_r;
    logic [FRAME_ID_WIDTH-1:0] id_cnt_r;
    logic [CRC_WIDTH-1:0]      seed_s;
    logic [CRC_WIDTH-1:0]      crc_s;
    logic [FRAME_WIDTH-1:0]    s2_frame_r;
    logic                      s2_valid_r;
    logic                      unused_crc_bits_s;

    // The incoming CRC field is overwritten, so its bits are deliberately dropped
    assign unused_crc_bits_s = ^tx_frame[CRC_WIDTH-1:0];

    // Classify the incoming header; illegal headers become a PAUSE control frame
    always_comb begin
        s1_body_s    = tx_frame[FRAME_WIDTH-1:CRC_WIDTH];
        s1_is_data_s = 1'b0;
        case (tx_frame[FRAME_WIDTH-1 -: 2])
            2'b01:   s1_is_data_s = 1'b1;
            2'b10:   s1_is_data_s = 1'b0;
            default: s1_body_s    = PAUSE_BODY;
        endcase
    end

    // Stage 1: capture the body and ID snapshot; only data frames advance the ID counter
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_body_r    <= '0;
            s1_is_data_r <= 1'b0;
            s1_id_r      <= '0;
            s1_valid_r   <= 1'b0;
            id_cnt_r     <= '0;
        end else begin
            s1_body_r    <= s1_body_s;
            s1_is_data_r <= s1_is_data_s;
            s1_id_r      <= id_cnt_r;
            s1_valid_r   <= 1'b1;
            if (s1_is_data_s) begin
                id_cnt_r <= id_cnt_r + FRAME_ID_WIDTH'(1);
            end else begin
                id_cnt_r <= id_cnt_r;
            end
        end
    end

    // CRC seed: the ID hides inside the seed of data frames; control frames use all-ones
    always_comb begin
        if (s1_is_data_r) begin
            seed_s = CRC_WIDTH'(s1_id_r);
        end else begin
            seed_s = {CRC_WIDTH{1'b1}};
        end
        crc_s = crc_calc(s1_body_r, seed_s);
    end

    // Stage 2: append the CRC; the bubble left by reset is forced to zero
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_frame_r <= '0;
            s2_valid_r <= 1'b0;
        end else if (s1_valid_r) begin
            s2_frame_r <= {s1_body_r, crc_s};
            s2_valid_r <= 1'b1;
        end else begin
            s2_frame_r <= '0;
            s2_valid_r <= 1'b0;
        end
    end

    assign tx_frame_id = id_cnt_r;

`ifdef TX_SCRAMBLER_EN
    // Self-synchronous x^58+x^39+1 scrambler, MSB first; returns {next_state, scrambled}
    function automatic logic [58+SCR_WIDTH-1:0] scramble(input logic [SCR_WIDTH-1:0] din,
                                                         input logic [57:0]          st_in);
        logic [57:0]          st;
        logic [SCR_WIDTH-1:0] dout;
        logic                 b;
        st   = st_in;
        dout = '0;
        for (int i = SCR_WIDTH - 1; i >= 0; i--) begin
            b       = din[i] ^ st[38] ^ st[57];
            dout[i] = b;
            st      = {st[56:0], b};
        end
        return {st, dout};
    endfunction

    logic [57:0]             scr_state_r;
    logic [58+SCR_WIDTH-1:0] scr_next_s;
    logic [FRAME_WIDTH-1:0]  s3_frame_r;
    logic                    s3_valid_r;

    // Scramble everything below the header using the running state
    always_comb begin
        scr_next_s = scramble(s2_frame_r[SCR_WIDTH-1:0], scr_state_r);
    end

    // Stage 3: the header passes through in clear; state advances only on real frames
    always_ff @(posedge clk) begin
        if (rst) begin
            s3_frame_r  <= '0;
            s3_valid_r  <= 1'b0;
            scr_state_r <= {58{1'b1}};
        end else if (s2_valid_r) begin
            s3_frame_r  <= {s2_frame_r[FRAME_WIDTH-1 -: 2], scr_next_s[SCR_WIDTH-1:0]};
            s3_valid_r  <= 1'b1;
            scr_state_r <= scr_next_s[58+SCR_WIDTH-1:SCR_WIDTH];
        end else begin
            s3_frame_r  <= '0;
            s3_valid_r  <= 1'b0;
            scr_state_r <= scr_state_r;
        end
    end

    assign enc_frame = s3_frame_r;
    assign enc_valid = s3_valid_r;
`else
    assign enc_frame = s2_frame_r;
    assign enc_valid = s2_valid_r;
`endif

endmodule

// File: tb/tb_tx_frame_encoder.sv
// Self-checking bench for tx_frame_encoder.
// The reference CRC is computed as polynomial remainder (seed*x^N + M*x^12) mod G.
module tb_tx_frame_encoder;

`ifdef TX_SCRAMBLER_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic         clk;
    logic         rst;
    logic [255:0] tx_frame;
    logic [255:0] enc_frame;
    logic         enc_valid;
    logic [7:0]   tx_frame_id;

    tx_frame_encoder dut (
        .clk        (clk),
        .rst        (rst),
        .tx_frame   (tx_frame),
        .enc_frame  (enc_frame),
        .enc_valid  (enc_valid),
        .tx_frame_id(tx_frame_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic         v;
        logic [255:0] f;
    } exp_t;

    typedef struct packed {
        logic         r;
        logic [1:0]   hdr;
        logic [15:0]  key;
        logic [31:0]  fill;
        logic         exp_v;
        logic [7:0]   exp_id;
    } vec_t;

    exp_t        exp_q[$];
    exp_t        cur;
    int          model_id;
    logic [57:0] ds_state;
    int          n_vec;
    int          n_miss;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] ref_crc(input logic [243:0] body, input logic [11:0] seed);
        logic [255:0] v;
        v = {body, 12'h000} ^ {seed, 244'd0};
        for (int i = 255; i >= 12; i--) begin
            if (v[i]) v[i -: 13] = v[i -: 13] ^ 13'h180F;
        end
        return v[11:0];
    endfunction

    function automatic logic [255:0] ref_encode(input logic [255:0] frame, input logic [7:0] id);
        logic [243:0] body;
        logic [11:0]  seed;
        body = frame[255:12];
        seed = 12'hFFF;
        if (frame[255:254] == 2'b01) seed = {4'h0, id};
        else if (frame[255:254] != 2'b10) body = {2'b10, 16'h0010, 226'd0};
        return {body, ref_crc(body, seed)};
    endfunction

    function automatic logic [255:0] mk_frame(input logic [1:0] hdr, input logic [15:0] key,
                                              input logic [31:0] fill);
        return {hdr, key, {7{fill}}, fill[13:0]};
    endfunction

    // One clock: drive at negedge, advance the model at posedge, check 1 ns later
    task automatic apply(input logic r, input logic [255:0] frame);
        exp_t        e;
        logic [253:0] ds;
        logic        b;
        @(negedge clk);
        rst      = r;
        tx_frame = frame;
        @(posedge clk);
        if (r) begin
            exp_q.delete();
            for (int k = 0; k < LAT - 1; k++) exp_q.push_back('0);
            cur      = '0;
            model_id = 0;
            ds_state = '1;
        end else begin
            e.v = 1'b1;
            e.f = ref_encode(frame, model_id[7:0]);
            if (frame[255:254] == 2'b01) model_id = (model_id + 1) % 256;
            exp_q.push_back(e);
            cur = exp_q.pop_front();
        end
        #1;
        check("enc_valid", 256'(enc_valid), 256'(cur.v));
        check("tx_frame_id", 256'(tx_frame_id), 256'(model_id[7:0]));
`ifdef TX_SCRAMBLER_EN
        if (cur.v) begin
            for (int i = 253; i >= 0; i--) begin
                b        = enc_frame[i];
                ds[i]    = b ^ ds_state[38] ^ ds_state[57];
                ds_state = {ds_state[56:0], b};
            end
            check("scr_header", 256'(enc_frame[255:254]), 256'(cur.f[255:254]));
            check("descrambled", {enc_frame[255:254], ds}, cur.f);
        end else begin
            check("enc_frame_idle", enc_frame, 256'd0);
        end
`else
        check("enc_frame", enc_frame, cur.f);
`endif
    endtask

    function automatic vec_t row(input logic r, input logic [1:0] hdr, input logic [15:0] key,
                                 input logic [31:0] fill, input logic ev, input logic [7:0] eid);
        vec_t t;
        t.r = r; t.hdr = hdr; t.key = key; t.fill = fill; t.exp_v = ev; t.exp_id = eid;
        return t;
    endfunction

    vec_t         tbl[16];
    logic [255:0] f;

    initial begin
        n_vec    = 0;
        n_miss   = 0;
        model_id = 0;
        ds_state = '1;
        rst      = 1'b1;
        tx_frame = '0;

        // T1 reset, T2 ID sequencing, T4 illegal headers
        tbl[0]  = row(1'b1, 2'b01, 16'hAAAA, 32'h1234_5678, 1'b0, 8'd0);
        tbl[1]  = row(1'b1, 2'b01, 16'hAAAA, 32'h1234_5678, 1'b0, 8'd0);
        tbl[2]  = row(1'b1, 2'b10, 16'h0001, 32'h0000_0000, 1'b0, 8'd0);
        tbl[3]  = row(1'b1, 2'b10, 16'h0001, 32'h0000_0000, 1'b0, 8'd0);
        tbl[4]  = row(1'b0, 2'b01, 16'h1111, 32'hDEAD_BEEF, 1'b0, 8'd1);
        tbl[5]  = row(1'b0, 2'b01, 16'h2222, 32'hCAFE_F00D, (LAT == 2), 8'd2);
        tbl[6]  = row(1'b0, 2'b01, 16'h3333, 32'h0000_0000, 1'b1, 8'd3);
        tbl[7]  = row(1'b0, 2'b01, 16'h4444, 32'hFFFF_FFFF, 1'b1, 8'd4);
        tbl[8]  = row(1'b0, 2'b01, 16'h5555, 32'h8000_0001, 1'b1, 8'd5);
        tbl[9]  = row(1'b0, 2'b10, 16'h0001, 32'h0000_0000, 1'b1, 8'd5);
        tbl[10] = row(1'b0, 2'b10, 16'h0001, 32'h0000_0000, 1'b1, 8'd5);
        tbl[11] = row(1'b0, 2'b10, 16'h0001, 32'h0000_0000, 1'b1, 8'd5);
        tbl[12] = row(1'b0, 2'b00, 16'h7777, 32'h5A5A_5A5A, 1'b1, 8'd5);
        tbl[13] = row(1'b0, 2'b11, 16'h8888, 32'hA5A5_A5A5, 1'b1, 8'd5);
        tbl[14] = row(1'b0, 2'b10, 16'h0001, 32'h0F0F_0F0F, 1'b1, 8'd5);
        tbl[15] = row(1'b0, 2'b10, 16'h0001, 32'h0000_0000, 1'b1, 8'd5);

        for (int i = 0; i < 16; i++) begin
            apply(tbl[i].r, mk_frame(tbl[i].hdr, tbl[i].key, tbl[i].fill));
            check("tbl_valid", 256'(enc_valid), 256'(tbl[i].exp_v));
            check("tbl_id", 256'(tx_frame_id), 256'(tbl[i].exp_id));
        end

        // T3: 256 identical data frames wrap the ID; frame 257 reuses seed 0
        f = mk_frame(2'b01, 16'hBEEF, 32'h0BAD_F00D);
        apply(1'b1, f);
        for (int i = 0; i < 256; i++) apply(1'b0, f);
        check("wrap_id", 256'(tx_frame_id), 256'd0);
        apply(1'b0, f);
        check("id_after_257", 256'(tx_frame_id), 256'd1);
        for (int i = 0; i < LAT; i++) apply(1'b0, mk_frame(2'b10, 16'h0001, 32'h0));

        // T5: reset with frames in flight, then no stale output after release
        apply(1'b0, mk_frame(2'b01, 16'h1357, 32'h2468_ACE0));
        apply(1'b0, mk_frame(2'b01, 16'h9BDF, 32'h1357_9BDF));
        apply(1'b1, mk_frame(2'b01, 16'h0000, 32'h0));
        check("rst_mid_valid", 256'(enc_valid), 256'd0);
        check("rst_mid_frame", enc_frame, 256'd0);
        check("rst_mid_id", 256'(tx_frame_id), 256'd0);
        for (int i = 0; i < LAT - 1; i++) begin
            apply(1'b0, mk_frame(2'b01, 16'h4242, 32'h4242_4242));
            check("no_stale_frame", enc_frame, 256'd0);
        end

        // Random traffic with occasional resets against the reference model
        for (int i = 0; i < 400; i++) begin
            f = {$urandom(), $urandom(), $urandom(), $urandom(),
                 $urandom(), $urandom(), $urandom(), $urandom()};
            f[255:254] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3))
                                                     : (($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10);
            apply(($urandom_range(0, 63) == 0), f);
        end
        for (int i = 0; i < LAT; i++) apply(1'b0, mk_frame(2'b10, 16'h0001, 32'h0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
